// File: rtl/prog_clock_divider_pkg.sv
// prog_clock_divider_pkg
// Shared constants and helpers for the programmable clock divider.
//   DIV_DEFAULT : half-period loaded into every channel at reset
//   clamp_div   : maps a requested half-period of 0 to 1 (0 is not a
//                 meaningful divisor; 1 gives clk/2)
package prog_clock_divider_pkg;

    localparam int unsigned DIV_DEFAULT = 16;

    function automatic int unsigned clamp_div(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/prog_clock_divider_channel.sv
// divider_channel
// One channel of the programmable divider: 50%-duty output with period
// 2*active_div, a one-cycle tick on every toggle, and a shadow divisor
// that is only applied at the end of a full period (high->low toggle)
// or on sync, so a ratio change never produces a runt pulse.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : count enable (low freezes count/out, tick forced low)
//   sync          : restart at out=0, count=0; applies any new divisor
//   load          : capture div_in (clamped) into the shadow register
//   div_in        : requested half-period
//   out, tick     : divided clock and toggle strobe (registered)
//   pending       : shadow value waiting to be applied
module divider_channel
    import prog_clock_divider_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sync,
    input  logic            load,
    input  logic [BITS-1:0] div_in,
    output logic            out,
    output logic            tick,
    output logic            pending
);

    logic [BITS-1:0] count_reg, count_next;
    logic [BITS-1:0] active_div_reg, active_div_next;
    logic [BITS-1:0] shadow_reg, shadow_next;
    logic            pending_reg, pending_next;
    logic            out_reg, out_next;
    logic            tick_reg, tick_next;

    logic [BITS-1:0] div_clamped;
    logic            boundary;

    assign div_clamped = BITS'(clamp_div(32'(div_in)));
    assign boundary    = (count_reg == active_div_reg - BITS'(1));

    always_comb begin
        count_next      = count_reg;
        active_div_next = active_div_reg;
        shadow_next     = shadow_reg;
        pending_next    = pending_reg;
        out_next        = out_reg;
        tick_next       = 1'b0;

        if (sync) begin
            count_next = '0;
            out_next   = 1'b0;
            // A load in the sync cycle is newer than any waiting shadow.
            if (load) begin
                active_div_next = div_clamped;
                pending_next    = 1'b0;
            end else if (pending_reg) begin
                active_div_next = shadow_reg;
                pending_next    = 1'b0;
            end
        end else if (en) begin
            if (boundary) begin
                count_next = '0;
                out_next   = ~out_reg;
                tick_next  = 1'b1;
                // Only a high->low toggle closes a full period.
                if (out_reg && pending_reg) begin
                    active_div_next = shadow_reg;
                    pending_next    = 1'b0;
                end
            end else begin
                count_next = count_reg + BITS'(1);
            end
        end

        // Capture after the boundary decision so a colliding load stays
        // pending for the next period instead of being applied now.
        if (load) begin
            shadow_next = div_clamped;
            if (!sync) begin
                pending_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg      <= '0;
            active_div_reg <= BITS'(DEFAULT_DIV);
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            out_reg        <= 1'b0;
            tick_reg       <= 1'b0;
        end else begin
            count_reg      <= count_next;
            active_div_reg <= active_div_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
            out_reg        <= out_next;
            tick_reg       <= tick_next;
        end
    end

    assign out     = out_reg;
    assign tick    = tick_reg;
    assign pending = pending_reg;

endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider
// Multi-channel runtime-programmable clock divider. Each channel makes a
// 50%-duty clock with period 2*DIV and a tick on every toggle; DIV is
// reloaded through a per-channel shadow register. A global sync restarts
// all channels phase-aligned.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : global count enable
//   sync     : aligned restart of all channels
//   load     : per-channel capture strobe for div_in
//   div_in   : new half-period, shared by all channels
//   out      : divided clocks
//   tick     : one-cycle pulse when the matching out toggles
//   pending  : a shadow divisor is waiting to be applied
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    input  logic [CHANNELS-1:0] load,
    input  logic [BITS-1:0]     div_in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            divider_channel #(
                .BITS        (BITS),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .sync    (sync),
                .load    (load[gi]),
                .div_in  (div_in),
                .out     (out[gi]),
                .tick    (tick[gi]),
                .pending (pending[gi])
            );
        end
    endgenerate

endmodule
